ir_receiver: RTL
================

Name: ir_receiver

Overview:
Receive-side decoder paired with the IR transmitter. It samples the demodulated IR line (rx_port), measures the width of each high and low phase, and classifies each symbol as preamble/stop, data 1, data 0 or invalid. When a full 32-bit frame ends with a stop symbol, it presents the word on rx_data with a one-cycle rx_received strobe. It sits between the IR front-end pin and the consumer of received words.

Parameters:
BASE_DELAY, 250, base time unit B in clock cycles (same value as the transmitter).
HDR_MIN, 16, minimum number of preamble symbols required before data is accepted.
TIMEOUT, 8*BASE_DELAY, maximum legal phase width in cycles; a longer phase aborts the frame.

Ports:
clock  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-high reset.
rx_enable  in  1  receiver enable; low forces IDLE.
rx_port  in  1  raw IR line; asynchronous to clock.
rx_data  out  32  last correctly received word, MSB first.
rx_received  out  1  one-cycle strobe: rx_data updated this cycle.
rx_error  out  1  one-cycle strobe: frame aborted on a protocol violation.
rx_busy  out  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset: rx_data=0, rx_received=0, rx_error=0, rx_busy=0. State=IDLE. All counters=0. Applies immediately, including mid-frame.
- Input path: 2-FF synchroniser into rx_s, plus a delayed copy for edge detection.
- Width counter: cleared on every rx_s edge, otherwise increments. Saturates at TIMEOUT.
- Line protocol:
  - Each symbol is a high phase H followed by an equal low phase.
  - Preamble and stop symbols: H=2B. Data 1: H=B. Data 0: H=3B.
- Classification, applied to both phases:
  - GLITCH: W < B/2
  - ONE: B/2 <= W < 3B/2
  - HDR: 3B/2 <= W < 5B/2
  - ZERO: 5B/2 <= W < 7B/2
  - LONG: W >= 7B/2
- Symbol check: a low phase measured at a rising edge must have the same class as the preceding high phase. A mismatch is an error.
- State IDLE:
  - A rising edge of rx_s while rx_enable=1 goes to PREAMBLE with hdr_cnt=0.
- State PREAMBLE:
  - Each HDR high phase increments hdr_cnt (saturates at 63).
  - A ONE or ZERO phase with hdr_cnt >= HDR_MIN goes to DATA. That bit is shifted in and bit_cnt=1.
  - A ONE or ZERO phase with hdr_cnt < HDR_MIN is an error.
- State DATA:
  - Each ONE/ZERO phase shifts in 1/0 MSB-first and increments bit_cnt.
  - bit_cnt reaching 32 goes to STOP.
  - HDR, GLITCH or LONG is an error.
- State STOP:
  - An HDR high phase means that, on the cycle its falling edge is processed, rx_data gets the shift register, rx_received=1, and the state returns to IDLE.
  - Any other class is an error.
- Latency: rx_received fires 3 clocks after the rx_port falling edge that ends the stop pulse (2 sync + 1 register).
- Timeout: the width counter reaching TIMEOUT in any non-IDLE state is an error. This applies to stuck-high and stuck-low lines.
- Error handling: rx_error pulses for one cycle and the state returns to IDLE. rx_data keeps its previous value. The shift register and counters are cleared.
- rx_enable deasserted mid-frame: return to IDLE at the next clock. No rx_error, no rx_received.
- rx_received and rx_error are never high in the same cycle.
- Back-to-back frames: a new rising edge immediately after a stop symbol starts a new frame from IDLE.

Decomposition:
- Package ir_pkg holds:
  - FRAME_BITS=32
  - the symbol-class enum {SYM_GLITCH, SYM_ONE, SYM_HDR, SYM_ZERO, SYM_LONG}
  - the state enum {IDLE, PREAMBLE, DATA, STOP}
  - a function returning the class thresholds derived from BASE_DELAY
  - the counter width, $clog2(TIMEOUT+1)
- Sub-module ir_pulse_meter contains the synchroniser, edge detect, saturating width counter and classifier. It outputs rise_strobe, fall_strobe, the class, and a timeout flag.
- ir_receiver holds the FSM, the shift register and the outputs.

Test Plan:
- Loopback from the transmitter with tx_data=0xBEEF0001 and 32 preamble symbols -> exactly one rx_received, 3 clocks after the stop falling edge. rx_data=0xBEEF0001, rx_error never high.
- Back-to-back frames 0x00000000 then 0xFFFFFFFF -> two rx_received strobes with the matching values, rx_busy low only between frames.
- Frame 0xA55A5AA5 with every phase width jittered by +/-60 cycles -> decodes 0xA55A5AA5.
- Only 8 preamble symbols before data -> rx_error at the first data pulse's falling edge, no rx_received, rx_data unchanged.
- Line held high for 2100 cycles during bit 10 -> rx_error when the counter reaches 2000, state IDLE, rx_data keeps the previous word.
- reset asserted mid-DATA -> all outputs 0 immediately. Separately, rx_enable dropped mid-frame -> rx_busy low next clock, no rx_error, no rx_received.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR receive path: symbol classes, FSM states,
// width-class thresholds and the width-counter sizing helper.
package ir_pkg;

    localparam int FRAME_BITS     = 32;
    localparam int BASE_DELAY_DEF = 250;
    localparam int TIMEOUT_DEF    = 8 * BASE_DELAY_DEF;

    typedef enum logic [2:0] {
        SYM_GLITCH,
        SYM_ONE,
        SYM_HDR,
        SYM_ZERO,
        SYM_LONG
    } sym_t;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        STOP
    } state_t;

    typedef struct packed {
        logic [31:0] one_min;
        logic [31:0] hdr_min;
        logic [31:0] zero_min;
        logic [31:0] long_min;
    } thr_t;

    // Class boundaries sit halfway between the nominal B, 2B and 3B widths.
    function automatic thr_t class_thresholds(input int base);
        thr_t t;
        t.one_min  = 32'(base / 2);
        t.hdr_min  = 32'((3 * base) / 2);
        t.zero_min = 32'((5 * base) / 2);
        t.long_min = 32'((7 * base) / 2);
        return t;
    endfunction

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/ir_pulse_meter.sv
// Synchronises the IR line, detects edges and classifies the width of each phase
// that just ended; the saturating counter also drives the stuck-line timeout flag.
module ir_pulse_meter
    import ir_pkg::*;
#(
    parameter int BASE_DELAY = BASE_DELAY_DEF,
    parameter int TIMEOUT    = 8 * BASE_DELAY
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_rx_port,
    output logic o_rise,
    output logic o_fall,
    output sym_t o_class,
    output logic o_timeout
);

    localparam int            CW      = cnt_width(TIMEOUT);
    localparam thr_t          THR     = class_thresholds(BASE_DELAY);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic [1:0]    r_sync;
    logic          r_s_d;
    logic [CW-1:0] r_cnt;
    logic          w_rx_s;
    logic          w_edge;
    logic [31:0]   w_width;

    assign w_rx_s = r_sync[1];
    assign o_rise = w_rx_s & ~r_s_d;
    assign o_fall = ~w_rx_s & r_s_d;
    assign w_edge = o_rise | o_fall;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b00;
            r_s_d  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_rx_port};
            r_s_d  <= w_rx_s;
            if (w_edge) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // On an edge cycle r_cnt still holds the width of the phase that just ended.
    assign w_width   = 32'(r_cnt);
    assign o_timeout = (r_cnt == CNT_MAX);

    always_comb begin
        o_class = SYM_LONG;
        if (w_width < THR.one_min) begin
            o_class = SYM_GLITCH;
        end else if (w_width < THR.hdr_min) begin
            o_class = SYM_ONE;
        end else if (w_width < THR.zero_min) begin
            o_class = SYM_HDR;
        end else if (w_width < THR.long_min) begin
            o_class = SYM_ZERO;
        end
    end

endmodule

// File: rtl/ir_receiver.sv
// IR frame decoder: preamble count, 32 data bits MSB first, stop symbol; word out
// with a one-cycle strobe 3 clocks after the stop falling edge, one-cycle error strobe.
module ir_receiver
    import ir_pkg::*;
#(
    parameter int BASE_DELAY = BASE_DELAY_DEF,
    parameter int HDR_MIN    = 16,
    parameter int TIMEOUT    = 8 * BASE_DELAY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_enable,
    input  logic        rx_port,
    output logic [31:0] rx_data,
    output logic        rx_received,
    output logic        rx_error,
    output logic        rx_busy
);

    localparam logic [5:0] HDR_MIN_C  = 6'(HDR_MIN);
    localparam logic [5:0] LAST_BIT_C = 6'(FRAME_BITS - 1);

    state_t                r_state, w_state_nx;
    logic [5:0]            r_hdr_cnt, w_hdr_nx;
    logic [5:0]            r_bit_cnt, w_bit_nx;
    logic [FRAME_BITS-1:0] r_shift, w_shift_nx;
    sym_t                  r_hi_cls, w_hi_nx;
    logic [31:0]           r_data;
    logic                  r_received, r_error;
    logic                  w_rise, w_fall, w_timeout;
    sym_t                  w_cls;
    logic                  w_is_bit, w_done, w_err;

    ir_pulse_meter #(
        .BASE_DELAY (BASE_DELAY),
        .TIMEOUT    (TIMEOUT)
    ) u_meter (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_rx_port (rx_port),
        .o_rise    (w_rise),
        .o_fall    (w_fall),
        .o_class   (w_cls),
        .o_timeout (w_timeout)
    );

    assign w_is_bit = (w_cls == SYM_ONE) || (w_cls == SYM_ZERO);

    always_comb begin
        w_state_nx = r_state;
        w_hdr_nx   = r_hdr_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_hi_nx    = r_hi_cls;
        w_done     = 1'b0;
        w_err      = 1'b0;
        if (!rx_enable) begin
            w_state_nx = IDLE;
        end else if (r_state == IDLE) begin
            if (w_rise) w_state_nx = PREAMBLE;
        end else if (w_timeout) begin
            w_err = 1'b1;
        end else if (w_rise && (w_cls != r_hi_cls)) begin
            w_err = 1'b1;
        end else if (w_fall) begin
            // High phases drive all decisions; the low phase is only cross-checked.
            w_hi_nx = w_cls;
            case (r_state)
                PREAMBLE: begin
                    if (w_cls == SYM_HDR) begin
                        if (r_hdr_cnt != 6'd63) w_hdr_nx = r_hdr_cnt + 6'd1;
                    end else if (w_is_bit && (r_hdr_cnt >= HDR_MIN_C)) begin
                        w_state_nx = DATA;
                        w_shift_nx = {r_shift[FRAME_BITS-2:0], (w_cls == SYM_ONE)};
                        w_bit_nx   = 6'd1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                DATA: begin
                    if (w_is_bit) begin
                        w_shift_nx = {r_shift[FRAME_BITS-2:0], (w_cls == SYM_ONE)};
                        w_bit_nx   = r_bit_cnt + 6'd1;
                        if (r_bit_cnt == LAST_BIT_C) w_state_nx = STOP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                STOP: begin
                    if (w_cls == SYM_HDR) w_done = 1'b1;
                    else                  w_err  = 1'b1;
                end
                default: w_state_nx = IDLE;
            endcase
        end
        if (w_err || w_done || (w_state_nx == IDLE)) begin
            w_state_nx = IDLE;
            w_hdr_nx   = '0;
            w_bit_nx   = '0;
            w_shift_nx = '0;
            w_hi_nx    = SYM_GLITCH;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hdr_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_hi_cls   <= SYM_GLITCH;
            r_data     <= '0;
            r_received <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hdr_cnt  <= w_hdr_nx;
            r_bit_cnt  <= w_bit_nx;
            r_shift    <= w_shift_nx;
            r_hi_cls   <= w_hi_nx;
            r_received <= w_done;
            r_error    <= w_err;
            if (w_done) r_data <= r_shift;
        end
    end

    assign rx_data     = r_data;
    assign rx_received = r_received;
    assign rx_error    = r_error;
    assign rx_busy     = (r_state != IDLE);

endmodule
